// File: rtl/note_chord_player_pkg.sv
// Shared types, constants and helpers for the chord player: wave modes,
// the per-note phase-step table builder and the waveform shaper.
package note_chord_player_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int NUM_NOTES = 64;
    localparam int STEP_W    = 32;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_MUTE   = 2'b11
    } wave_mode_e;

    typedef logic [NUM_NOTES-1:0][STEP_W-1:0] step_tab_t;

    // Wide enough for twelfth powers of the integer terms used below.
    typedef logic [639:0] wide_t;

    function automatic wide_t pow12(input wide_t x);
        wide_t r;
        r = wide_t'(1);
        for (int i = 0; i < 12; i++) begin
            r = r * x;
        end
        return r;
    endfunction

    // round(55 * 2^((n-1)/12) * 2^acc_w / 48000) without real arithmetic:
    // s is the largest integer with (2s-1)*9600 <= 22*2^(acc_w+oct)*2^(semi/12),
    // compared after raising both sides to the twelfth power.
    function automatic logic [STEP_W-1:0] round_step(input int n, input int acc_w);
        wide_t            rhs;
        wide_t            a;
        logic [STEP_W-1:0] s;
        logic [STEP_W-1:0] cand;
        int               oct;
        int               semi;
        oct  = (n - 1) / 12;
        semi = (n - 1) % 12;
        rhs  = pow12(wide_t'(22) << (acc_w + oct)) << semi;
        s    = '0;
        for (int b = acc_w - 1; b >= 0; b--) begin
            cand = s | (32'd1 << b);
            a    = ((wide_t'(cand) << 1) - wide_t'(1)) * wide_t'(9600);
            if (pow12(a) <= rhs) begin
                s = cand;
            end
        end
        return s;
    endfunction

    // Entry 0 is the rest note and never advances the phase.
    function automatic step_tab_t build_step_table(input int acc_w);
        step_tab_t tab;
        tab = '0;
        for (int n = 1; n < NUM_NOTES; n++) begin
            tab[n] = round_step(n, acc_w);
        end
        return tab;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] wave_sample(input wave_mode_e mode,
                                                              input logic [15:0] t);
        logic [15:0] u2;
        logic [15:0] res;
        u2 = {t[14:0], 1'b0};
        case (mode)
            WAVE_SQUARE: res = t[15] ? 16'h8000 : 16'h7FFF;
            WAVE_SAW:    res = {~t[15], t[14:0]};
            WAVE_TRI:    res = t[15] ? (16'h7FFF - u2) : (u2 - 16'h8000);
            default:     res = '0;
        endcase
        return $signed(res);
    endfunction

endpackage

// File: rtl/note_chord_player_if.sv
// Control/sample bus of the chord player; the sequencer side is master.
interface note_chord_player_if
    import note_chord_player_pkg::*;
#(
    parameter int NUM_VOICES = 4
);
    localparam int SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                        play_enable;
    logic                        beat;
    logic                        load_new_note;
    logic [SEL_W-1:0]            voice_sel;
    logic [NOTE_W-1:0]           note_to_load;
    logic [DUR_W-1:0]            duration_to_load;
    logic [1:0]                  wave_mode;
    logic                        generate_next_sample;
    logic signed [SAMPLE_W-1:0]  sample_out;
    logic                        new_sample_ready;
    logic [NUM_VOICES-1:0]       voice_busy;
    logic [NUM_VOICES-1:0]       done_with_note;

    modport master (
        output play_enable, beat, load_new_note, voice_sel, note_to_load,
               duration_to_load, wave_mode, generate_next_sample,
        input  sample_out, new_sample_ready, voice_busy, done_with_note
    );

    modport slave (
        input  play_enable, beat, load_new_note, voice_sel, note_to_load,
               duration_to_load, wave_mode, generate_next_sample,
        output sample_out, new_sample_ready, voice_busy, done_with_note
    );

endinterface

// File: rtl/note_chord_player_voice.sv
// One voice: note/duration/mode latch, beat countdown, phase accumulator
// and a registered waveform value captured for the mixer stage.
module note_voice
    import note_chord_player_pkg::*;
#(
    parameter int        ACC_W    = 22,
    parameter step_tab_t STEP_TAB = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic [NOTE_W-1:0]          note_i,
    input  logic [DUR_W-1:0]           dur_i,
    input  wave_mode_e                 mode_i,
    input  logic                       beat_i,
    input  logic                       step_i,
    input  logic                       capture_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic signed [SAMPLE_W-1:0] value_o
);

    logic [NOTE_W-1:0]          note_q,  note_d;
    logic [DUR_W-1:0]           count_q, count_d;
    wave_mode_e                 mode_q,  mode_d;
    logic [ACC_W-1:0]           phase_q, phase_d;
    logic                       busy_q,  busy_d;
    logic                       done_q,  done_d;
    logic signed [SAMPLE_W-1:0] value_q, value_d;
    logic                       audible;

    assign audible = busy_q && (note_q != '0) && (mode_q != WAVE_MUTE);

    // The count wraps 0 -> 63, so a loaded 0 runs for 64 beats.
    always_comb begin
        note_d  = note_q;
        count_d = count_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        value_d = value_q;

        if (step_i && busy_q && (note_q != '0)) begin
            phase_d = phase_q + STEP_TAB[note_q][ACC_W-1:0];
        end
        if (beat_i && busy_q) begin
            count_d = count_q - 1'b1;
            if (count_q == DUR_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
        // A load restarts the voice and swallows an end-of-note landing on the same edge.
        if (load_i) begin
            note_d  = note_i;
            count_d = dur_i;
            mode_d  = mode_i;
            phase_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
        if (capture_i) begin
            value_d = audible ? wave_sample(mode_q, phase_q[ACC_W-1 -: SAMPLE_W]) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_q  <= '0;
            count_q <= '0;
            mode_q  <= WAVE_SQUARE;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
        end else begin
            note_q  <= note_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign value_o = value_q;

endmodule

// File: rtl/note_chord_player.sv
// Polyphonic note player: NUM_VOICES voices mixed into one 16-bit sample,
// two-stage pipeline (voice waveform register, then mix register).
module note_chord_player
    import note_chord_player_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 22
) (
    input  logic                clk,
    input  logic                reset,
    note_chord_player_if.slave  bus
);

    localparam int        LOG_V    = $clog2(NUM_VOICES);
    localparam int        SEL_W    = (NUM_VOICES > 1) ? LOG_V : 1;
    localparam int        MIX_W    = SAMPLE_W + LOG_V;
    localparam step_tab_t STEP_TAB = build_step_table(ACC_W);

    logic                       req_accept;
    logic                       beat_accept;
    logic                       req_valid_q;
    logic                       mix_valid_q;
    logic                       ready_q;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic signed [MIX_W-1:0]    mix_sum;
    logic [NUM_VOICES-1:0]      busy_vec;
    logic [NUM_VOICES-1:0]      done_vec;
    logic signed [SAMPLE_W-1:0] voice_value [NUM_VOICES];

    assign req_accept  = bus.play_enable & bus.generate_next_sample;
    assign beat_accept = bus.play_enable & bus.beat;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic load_hit;
            assign load_hit = bus.load_new_note &&
                              ((NUM_VOICES == 1) || (bus.voice_sel == SEL_W'(gi)));

            note_voice #(
                .ACC_W    (ACC_W),
                .STEP_TAB (STEP_TAB)
            ) u_voice (
                .clk       (clk),
                .reset     (reset),
                .load_i    (load_hit),
                .note_i    (bus.note_to_load),
                .dur_i     (bus.duration_to_load),
                .mode_i    (wave_mode_e'(bus.wave_mode)),
                .beat_i    (beat_accept),
                .step_i    (req_accept),
                .capture_i (req_valid_q),
                .busy_o    (busy_vec[gi]),
                .done_o    (done_vec[gi]),
                .value_o   (voice_value[gi])
            );
        end
    endgenerate

    // Full-width sum cannot overflow; the shift is a floor divide by NUM_VOICES.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_sum = mix_sum + MIX_W'(voice_value[i]);
        end
        sample_d = mix_valid_q ? SAMPLE_W'(mix_sum >>> LOG_V) : sample_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_q <= 1'b0;
            mix_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            sample_q    <= '0;
        end else begin
            req_valid_q <= req_accept;
            mix_valid_q <= req_valid_q;
            ready_q     <= mix_valid_q;
            sample_q    <= sample_d;
        end
    end

    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = ready_q;
    assign bus.voice_busy       = busy_vec;
    assign bus.done_with_note   = done_vec;

endmodule

// File: tb/tb_note_chord_player.sv
// Randomised and directed bench for note_chord_player with a queue-based
// scoreboard fed by a behavioural voice model.
module tb_note_chord_player;

    localparam int     NV   = 4;
    localparam int     AW   = 22;
    localparam longint MODV = longint'(1) << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_chord_player_if #(.NUM_VOICES(NV)) bus ();

    note_chord_player #(
        .NUM_VOICES (NV),
        .ACC_W      (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     vectors     = 0;
    int     miscompares = 0;
    int     sb [$];
    longint step_tab [64];

    int     m_note  [NV];
    int     m_rem   [NV];
    int     m_mode  [NV];
    longint m_phase [NV];
    bit     m_busy  [NV];
    bit     m_done  [NV];

    function automatic void check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        sb.delete();
        for (int v = 0; v < NV; v++) begin
            m_note[v] = 0; m_rem[v] = 0; m_mode[v] = 0;
            m_phase[v] = 0; m_busy[v] = 1'b0; m_done[v] = 1'b0;
        end
    endfunction

    function automatic int voice_level(input int v);
        int t;
        int u;
        if (!m_busy[v] || m_note[v] == 0) return 0;
        t = int'(m_phase[v] / (MODV / 65536));
        u = t % 32768;
        case (m_mode[v])
            0:       return (t >= 32768) ? -32768 : 32767;
            1:       return t - 32768;
            2:       return (t >= 32768) ? 32767 - 2 * u : 2 * u - 32768;
            default: return 0;
        endcase
    endfunction

    function automatic int expected_mix();
        int sum = 0;
        for (int v = 0; v < NV; v++) sum += voice_level(v);
        if (sum >= 0) return sum / NV;
        return -((-sum + NV - 1) / NV);
    endfunction

    function automatic void model_edge(input bit pe, input bit bt, input bit ld, input int sel,
                                       input int nt, input int dr, input int wm, input bit gen);
        for (int v = 0; v < NV; v++) begin
            m_done[v] = 1'b0;
            if (pe && gen && m_busy[v] && m_note[v] != 0)
                m_phase[v] = (m_phase[v] + step_tab[m_note[v]]) % MODV;
            if (pe && bt && m_busy[v]) begin
                m_rem[v]--;
                if (m_rem[v] == 0) begin
                    m_busy[v] = 1'b0;
                    m_done[v] = 1'b1;
                end
            end
            if (ld && sel == v) begin
                m_note[v] = nt; m_mode[v] = wm; m_phase[v] = 0;
                m_rem[v] = (dr == 0) ? 64 : dr;
                m_busy[v] = 1'b1; m_done[v] = 1'b0;
            end
        end
        if (pe && gen) sb.push_back(expected_mix());
    endfunction

    function automatic void check_status();
        logic [NV-1:0] eb;
        logic [NV-1:0] ed;
        for (int v = 0; v < NV; v++) begin
            eb[v] = m_busy[v];
            ed[v] = m_done[v];
        end
        check("voice_busy", longint'(bus.voice_busy), longint'(eb));
        check("done_with_note", longint'(bus.done_with_note), longint'(ed));
    endfunction

    task automatic drive_idle();
        bus.play_enable = 1'b0; bus.beat = 1'b0; bus.load_new_note = 1'b0;
        bus.voice_sel = '0; bus.note_to_load = '0; bus.duration_to_load = '0;
        bus.wave_mode = '0; bus.generate_next_sample = 1'b0;
    endtask

    task automatic cycle(input bit pe, input bit bt, input bit ld, input int sel,
                         input int nt, input int dr, input int wm, input bit gen);
        @(negedge clk);
        check_status();
        bus.play_enable          = pe;
        bus.beat                 = bt;
        bus.load_new_note        = ld;
        bus.voice_sel            = 2'(sel);
        bus.note_to_load         = 6'(nt);
        bus.duration_to_load     = 6'(dr);
        bus.wave_mode            = 2'(wm);
        bus.generate_next_sample = gen;
        if (ld) $display("load v%0d note %0d dur %0d wave %0d (play %0d beat %0d req %0d)",
                         sel, nt, dr, wm, pe, bt, gen);
        model_edge(pe, bt, ld, sel, nt, dr, wm, gen);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit pe;
            bit ld;
            int nt;
            int dr;
            pe = ($urandom_range(0, 99) < 88);
            ld = ($urandom_range(0, 99) < 10);
            nt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            dr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            cycle(pe, ($urandom_range(0, 99) < 30), ld, int'($urandom_range(0, NV - 1)),
                  nt, dr, int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 55));
        end
    endtask

    // Scoreboard side: every ready pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (bus.new_sample_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                check("sample_out", longint'(bus.sample_out), longint'(sb.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int n = 0; n < 64; n++) begin
            step_tab[n] = (n == 0) ? 0 :
                longint'($floor(55.0 * (2.0 ** ((n - 1) / 12.0)) * (2.0 ** AW) / 48000.0 + 0.5));
        end
        model_clear();
        drive_idle();
        reset = 1'b0;

        @(negedge clk);
        check("reset_sample_out", longint'(bus.sample_out), 0);
        check("reset_ready", longint'(bus.new_sample_ready), 0);
        check_status();
        @(negedge clk);
        reset = 1'b1;

        // Saw on voice 0, three requests, then the two-beat note ends.
        cycle(1'b1, 1'b0, 1'b1, 0, 1, 2, 1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(3);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(3);

        // Play gate low: beats and requests must be ignored.
        cycle(1'b1, 1'b0, 1'b1, 0, 10, 3, 0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(2);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(2);

        // Reload voice 1 exactly on its final beat.
        cycle(1'b1, 1'b0, 1'b1, 1, 5, 1, 2, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1, 7, 2, 1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(3);

        // Full-scale square chord, then all rests, then all muted.
        for (int v = 0; v < NV; v++) cycle(1'b1, 1'b0, 1'b1, v, 1, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(3);
        for (int v = 0; v < NV; v++) cycle(1'b1, 1'b0, 1'b1, v, 0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(3);
        for (int v = 0; v < NV; v++) cycle(1'b1, 1'b0, 1'b1, v, 9, 0, 3, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(3);

        random_cycles(1500);

        // Reset in the middle of a note with samples in flight.
        cycle(1'b1, 1'b0, 1'b1, 2, 30, 20, 2, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        drive_idle();
        #1;
        model_clear();
        check("midreset_sample_out", longint'(bus.sample_out), 0);
        check("midreset_ready", longint'(bus.new_sample_ready), 0);
        check_status();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        random_cycles(300);

        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
